// File: rtl/mio_bus_arbiter_if.sv
// Signal bundle between the two MIO masters, the arbiter and the MIO bus decoder.
// The arbiter connects through the slave modport; the environment uses master.
interface mio_bus_arbiter_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic [3:0]    m0_amp;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic [3:0]    m1_amp;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;

    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [3:0]    bus_amp;
    logic [DW-1:0] bus_rdata;

    logic [1:0]    gnt;
    logic          cpu_stall;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_amp,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_amp,
        input  bus_rdata,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output bus_we, bus_addr, bus_wdata, bus_amp,
        output gnt, cpu_stall
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_amp,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_amp,
        output bus_rdata,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  bus_we, bus_addr, bus_wdata, bus_amp,
        input  gnt, cpu_stall
    );
endinterface

// File: rtl/mio_bus_arbiter.sv
// Two-master MIO bus arbiter: registered grant, round-robin tie-break and a burst
// cap; bus muxing, acks and the CPU stall are decoded combinationally from the grant.
module mio_bus_arbiter #(
    parameter int unsigned DW        = 32,
    parameter int unsigned AW        = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rstn,
    mio_bus_arbiter_if.slave bus
);
    localparam int unsigned   CW      = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t        state;
    logic          last;
    logic [CW-1:0] beat_cnt;

    logic          own0;
    logic          own1;
    logic          m0_ack;
    logic          m1_ack;
    logic          we_mux;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;
    logic [3:0]    amp_mux;

    // last = most recent owner; reset to 1 so m0 wins the first tie.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            last     <= 1'b1;
            beat_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.m0_req && (!bus.m1_req || last)) begin
                        state    <= G0;
                        last     <= 1'b0;
                        beat_cnt <= '0;
                    end else if (bus.m1_req) begin
                        state    <= G1;
                        last     <= 1'b1;
                        beat_cnt <= '0;
                    end
                end
                G0: begin
                    if (bus.m0_req) begin
                        if (bus.m1_req && beat_cnt == CNT_MAX) begin
                            state    <= G1;
                            last     <= 1'b1;
                            beat_cnt <= '0;
                        end else if (beat_cnt != CNT_MAX) begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
                    end else if (bus.m1_req) begin
                        state    <= G1;
                        last     <= 1'b1;
                        beat_cnt <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                G1: begin
                    if (bus.m1_req) begin
                        if (bus.m0_req && beat_cnt == CNT_MAX) begin
                            state    <= G0;
                            last     <= 1'b0;
                            beat_cnt <= '0;
                        end else if (beat_cnt != CNT_MAX) begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
                    end else if (bus.m0_req) begin
                        state    <= G0;
                        last     <= 1'b0;
                        beat_cnt <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign own0 = (state == G0);
    assign own1 = (state == G1);

    // Write strobe is qualified by the owner's req so an abandoned access never writes.
    always_comb begin
        we_mux    = 1'b0;
        addr_mux  = '0;
        wdata_mux = '0;
        amp_mux   = '0;
        if (own0) begin
            we_mux    = bus.m0_we & bus.m0_req;
            addr_mux  = bus.m0_addr;
            wdata_mux = bus.m0_wdata;
            amp_mux   = bus.m0_amp;
        end else if (own1) begin
            we_mux    = bus.m1_we & bus.m1_req;
            addr_mux  = bus.m1_addr;
            wdata_mux = bus.m1_wdata;
            amp_mux   = bus.m1_amp;
        end
    end

    assign bus.bus_we    = we_mux;
    assign bus.bus_addr  = addr_mux;
    assign bus.bus_wdata = wdata_mux;
    assign bus.bus_amp   = amp_mux;

    assign m0_ack        = own0 & bus.m0_req;
    assign m1_ack        = own1 & bus.m1_req;
    assign bus.m0_ack    = m0_ack;
    assign bus.m1_ack    = m1_ack;
    assign bus.m0_rdata  = own0 ? bus.bus_rdata : '0;
    assign bus.m1_rdata  = own1 ? bus.bus_rdata : '0;

    assign bus.gnt       = {own1, own0};
    assign bus.cpu_stall = bus.m0_req & ~m0_ack;
endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Self-checking bench for mio_bus_arbiter: two instances (burst cap 4 and 1) share stimulus.
// Directed scenarios plus a randomized run against an owner/run-length reference model.
`timescale 1ns/1ps
module tb_mio_bus_arbiter;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    mio_bus_arbiter_if #(.DW(32), .AW(32)) ia ();
    mio_bus_arbiter_if #(.DW(32), .AW(32)) ib ();

    mio_bus_arbiter #(.DW(32), .AW(32), .MAX_BURST(4)) dut_a (.clk(clk), .rstn(rstn), .bus(ia));
    mio_bus_arbiter #(.DW(32), .AW(32), .MAX_BURST(1)) dut_b (.clk(clk), .rstn(rstn), .bus(ib));

    assign ib.m0_req    = ia.m0_req;
    assign ib.m0_we     = ia.m0_we;
    assign ib.m0_addr   = ia.m0_addr;
    assign ib.m0_wdata  = ia.m0_wdata;
    assign ib.m0_amp    = ia.m0_amp;
    assign ib.m1_req    = ia.m1_req;
    assign ib.m1_we     = ia.m1_we;
    assign ib.m1_addr   = ia.m1_addr;
    assign ib.m1_wdata  = ia.m1_wdata;
    assign ib.m1_amp    = ia.m1_amp;
    assign ib.bus_rdata = ia.bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner (-1 idle), last winner, beats served in the current tenure.
    int owner  [2];
    int last_w [2];
    int run    [2];
    int mb     [2] = '{4, 1};

    // Payload must not change while a request is pending and unacknowledged.
    a_m0_hold: assert property (@(posedge clk) disable iff (!rstn)
        (ia.m0_req && !ia.m0_ack) |=> (!ia.m0_req || ($stable(ia.m0_we) && $stable(ia.m0_addr)
                                        && $stable(ia.m0_wdata) && $stable(ia.m0_amp))));
    a_m1_hold: assert property (@(posedge clk) disable iff (!rstn)
        (ia.m1_req && !ia.m1_ack) |=> (!ia.m1_req || ($stable(ia.m1_we) && $stable(ia.m1_addr)
                                        && $stable(ia.m1_wdata) && $stable(ia.m1_amp))));
    a_gnt_a: assert property (@(posedge clk) ia.gnt != 2'b11);
    a_gnt_b: assert property (@(posedge clk) ib.gnt != 2'b11);

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            owner[k]  = -1;
            last_w[k] = 1;
            run[k]    = 0;
        end
    endfunction

    function automatic void model_step(bit r0, bit r1);
        bit r [2];
        int o;
        int nxt;
        r[0] = r0;
        r[1] = r1;
        for (int k = 0; k < 2; k++) begin
            o   = owner[k];
            nxt = o;
            if (o < 0) begin
                if (r0 && r1)  nxt = 1 - last_w[k];
                else if (r0)   nxt = 0;
                else if (r1)   nxt = 1;
            end else if (r[o]) begin
                run[k] = run[k] + 1;
                if (r[1 - o] && run[k] >= mb[k]) nxt = 1 - o;
            end else begin
                nxt = r[1 - o] ? 1 - o : -1;
            end
            if (nxt >= 0 && nxt != o) begin
                last_w[k] = nxt;
                run[k]    = 0;
            end
            owner[k] = nxt;
        end
    endfunction

    task automatic clear_inputs();
        ia.m0_req = 1'b0; ia.m0_we = 1'b0; ia.m0_addr = '0; ia.m0_wdata = '0; ia.m0_amp = '0;
        ia.m1_req = 1'b0; ia.m1_we = 1'b0; ia.m1_addr = '0; ia.m1_wdata = '0; ia.m1_amp = '0;
        ia.bus_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rstn = 1'b0;
        ia.m0_req = 1'b1; ia.m0_we = 1'b1; ia.m0_addr = 32'h44;
        ia.m1_req = 1'b1; ia.m1_we = 1'b1; ia.m1_addr = 32'h88;
        ia.bus_rdata = 32'hCAFEF00D;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (ia.gnt !== 2'b00 || ib.gnt !== 2'b00) begin
            n_fail++; $display("FAIL rst_gnt: got %b/%b expected 00/00", ia.gnt, ib.gnt);
        end
        n_checks++;
        if ({ia.m1_ack, ia.m0_ack} !== 2'b00) begin
            n_fail++; $display("FAIL rst_ack: got %b expected 00", {ia.m1_ack, ia.m0_ack});
        end
        n_checks++;
        if (ia.bus_we !== 1'b0 || ia.bus_addr !== 32'h0) begin
            n_fail++; $display("FAIL rst_bus: got we=%b addr=%h expected we=0 addr=0", ia.bus_we, ia.bus_addr);
        end
        n_checks++;
        if (ia.m0_rdata !== 32'h0 || ia.m1_rdata !== 32'h0) begin
            n_fail++; $display("FAIL rst_rdata: got %h/%h expected 0/0", ia.m0_rdata, ia.m1_rdata);
        end
        clear_inputs();
        rstn = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (ia.gnt !== 2'b00 || ia.cpu_stall !== 1'b0) begin
            n_fail++; $display("FAIL rst_idle: got gnt=%b stall=%b expected gnt=00 stall=0", ia.gnt, ia.cpu_stall);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        do_reset();
        ia.bus_rdata = 32'hDEADBEEF;
        ia.m0_req = 1'b1; ia.m0_we = 1'b0; ia.m0_addr = 32'h10; ia.m0_amp = 4'hF;
        @(negedge clk);
        n_checks++;
        if (ia.gnt !== 2'b00 || ia.m0_ack !== 1'b0 || ia.cpu_stall !== 1'b1) begin
            n_fail++; $display("FAIL rd_wait: got gnt=%b ack=%b stall=%b expected 00/0/1", ia.gnt, ia.m0_ack, ia.cpu_stall);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (ia.gnt !== 2'b01 || ia.m0_ack !== 1'b1 || ia.cpu_stall !== 1'b0) begin
            n_fail++; $display("FAIL rd_grant: got gnt=%b ack=%b stall=%b expected 01/1/0", ia.gnt, ia.m0_ack, ia.cpu_stall);
        end
        n_checks++;
        if (ia.m0_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL rd_data: got %h expected deadbeef", ia.m0_rdata);
        end
        n_checks++;
        if (ia.bus_addr !== 32'h10 || ia.bus_we !== 1'b0 || ia.bus_amp !== 4'hF) begin
            n_fail++; $display("FAIL rd_bus: got addr=%h we=%b amp=%h expected 10/0/f", ia.bus_addr, ia.bus_we, ia.bus_amp);
        end
        @(posedge clk); #1;
        ia.m0_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ia.m0_ack !== 1'b0 || ia.cpu_stall !== 1'b0) begin
            n_fail++; $display("FAIL rd_after: got ack=%b stall=%b expected 0/0", ia.m0_ack, ia.cpu_stall);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (ia.gnt !== 2'b00) begin
            n_fail++; $display("FAIL rd_idle: got gnt=%b expected 00", ia.gnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        logic [1:0] e_ack;
        do_reset();
        ia.m0_req = 1'b1; ia.m0_addr = 32'h100;
        ia.m1_req = 1'b1; ia.m1_addr = 32'h200;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c == 0)                      e_ack = 2'b00;
            else if (((c - 1) / 4) % 2 == 0) e_ack = 2'b01;
            else                             e_ack = 2'b10;
            n_checks++;
            if ({ia.m1_ack, ia.m0_ack} !== e_ack) begin
                n_fail++; $display("FAIL rr_ack c=%0d: got %b expected %b", c, {ia.m1_ack, ia.m0_ack}, e_ack);
            end
            n_checks++;
            if (ia.gnt !== e_ack) begin
                n_fail++; $display("FAIL rr_gnt c=%0d: got %b expected %b", c, ia.gnt, e_ack);
            end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_m1_write();
        int writes;
        do_reset();
        ia.m1_req = 1'b1; ia.m1_we = 1'b1; ia.m1_addr = 32'hFFFF000C;
        ia.m1_wdata = 32'h1234; ia.m1_amp = 4'hF;
        @(negedge clk);
        n_checks++;
        if (ia.bus_we !== 1'b0 || ia.gnt !== 2'b00) begin
            n_fail++; $display("FAIL wr_wait: got we=%b gnt=%b expected 0/00", ia.bus_we, ia.gnt);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (ia.gnt !== 2'b10 || ia.m1_ack !== 1'b1 || ia.bus_we !== 1'b1) begin
            n_fail++; $display("FAIL wr_beat: got gnt=%b ack=%b we=%b expected 10/1/1", ia.gnt, ia.m1_ack, ia.bus_we);
        end
        n_checks++;
        if (ia.bus_wdata !== 32'h1234 || ia.bus_addr !== 32'hFFFF000C) begin
            n_fail++; $display("FAIL wr_payload: got data=%h addr=%h expected 1234/ffff000c", ia.bus_wdata, ia.bus_addr);
        end
        @(posedge clk); #1;
        ia.m1_we = 1'b0; ia.m1_addr = 32'hFFFF0010;
        writes = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ia.bus_we === 1'b1) writes++;
            n_checks++;
            if (ia.gnt !== 2'b10 || ia.m1_ack !== 1'b1) begin
                n_fail++; $display("FAIL wr_hold c=%0d: got gnt=%b ack=%b expected 10/1", c, ia.gnt, ia.m1_ack);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (writes != 0) begin
            n_fail++; $display("FAIL wr_once: got %0d extra write cycles expected 0", writes);
        end
        clear_inputs();
    endtask

    task automatic test_release();
        do_reset();
        ia.m0_req = 1'b1; ia.m0_we = 1'b1; ia.m0_addr = 32'h20; ia.m0_wdata = 32'h55;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (ia.m0_ack !== 1'b1 || ia.bus_we !== 1'b1) begin
            n_fail++; $display("FAIL rel_beat: got ack=%b we=%b expected 1/1", ia.m0_ack, ia.bus_we);
        end
        @(posedge clk); #1;
        ia.m0_req = 1'b0;
        ia.m1_req = 1'b1; ia.m1_we = 1'b0; ia.m1_addr = 32'h30;
        @(negedge clk);
        n_checks++;
        if (ia.gnt !== 2'b01 || ia.bus_we !== 1'b0 || {ia.m1_ack, ia.m0_ack} !== 2'b00) begin
            n_fail++; $display("FAIL rel_gap: got gnt=%b we=%b ack=%b expected 01/0/00",
                               ia.gnt, ia.bus_we, {ia.m1_ack, ia.m0_ack});
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (ia.gnt !== 2'b10 || ia.m1_ack !== 1'b1 || ia.bus_addr !== 32'h30) begin
            n_fail++; $display("FAIL rel_switch: got gnt=%b ack=%b addr=%h expected 10/1/30", ia.gnt, ia.m1_ack, ia.bus_addr);
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        ia.m1_req = 1'b1; ia.m1_we = 1'b1; ia.m1_addr = 32'h40; ia.m1_wdata = 32'hAA;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (ia.bus_we !== 1'b1 || ia.gnt !== 2'b10) begin
            n_fail++; $display("FAIL rmw_pre: got we=%b gnt=%b expected 1/10", ia.bus_we, ia.gnt);
        end
        #1 rstn = 1'b0;
        #1;
        n_checks++;
        if (ia.bus_we !== 1'b0 || ia.gnt !== 2'b00 || ia.m1_ack !== 1'b0) begin
            n_fail++; $display("FAIL rmw_drop: got we=%b gnt=%b ack=%b expected 0/00/0", ia.bus_we, ia.gnt, ia.m1_ack);
        end
        ia.m0_req = 1'b1; ia.m0_addr = 32'h50;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ia.gnt !== 2'b00) begin
            n_fail++; $display("FAIL rmw_idle: got gnt=%b expected 00", ia.gnt);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (ia.gnt !== 2'b01 || ia.m0_ack !== 1'b1 || ia.m1_ack !== 1'b0) begin
            n_fail++; $display("FAIL rmw_tie: got gnt=%b acks=%b expected 01/01", ia.gnt, {ia.m1_ack, ia.m0_ack});
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_burst1();
        logic [1:0]  e_ack;
        logic [31:0] e_addr;
        do_reset();
        ia.m0_req = 1'b1; ia.m0_addr = 32'hA0;
        ia.m1_req = 1'b1; ia.m1_addr = 32'hB0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0)                begin e_ack = 2'b00; e_addr = 32'h0;  end
            else if ((c - 1) % 2 == 0) begin e_ack = 2'b01; e_addr = 32'hA0; end
            else                       begin e_ack = 2'b10; e_addr = 32'hB0; end
            n_checks++;
            if ({ib.m1_ack, ib.m0_ack} !== e_ack) begin
                n_fail++; $display("FAIL b1_ack c=%0d: got %b expected %b", c, {ib.m1_ack, ib.m0_ack}, e_ack);
            end
            n_checks++;
            if (ib.bus_addr !== e_addr) begin
                n_fail++; $display("FAIL b1_addr c=%0d: got %h expected %h", c, ib.bus_addr, e_addr);
            end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_random();
        int          o;
        logic [1:0]  a_gnt, e_gnt, a_ack, e_ack;
        logic        a_we, e_we, a_stall, e_stall;
        logic [31:0] a_addr, e_addr, a_wd, e_wd;
        logic [63:0] a_rd, e_rd;
        logic        all_ack0, all_ack1;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            ia.bus_rdata = $urandom;
            @(negedge clk);
            all_ack0 = 1'b1;
            all_ack1 = 1'b1;
            for (int k = 0; k < 2; k++) begin
                o = owner[k];
                if (k == 0) begin
                    a_gnt = ia.gnt; a_ack = {ia.m1_ack, ia.m0_ack}; a_we = ia.bus_we;
                    a_addr = ia.bus_addr; a_wd = ia.bus_wdata; a_rd = {ia.m1_rdata, ia.m0_rdata}; a_stall = ia.cpu_stall;
                end else begin
                    a_gnt = ib.gnt; a_ack = {ib.m1_ack, ib.m0_ack}; a_we = ib.bus_we;
                    a_addr = ib.bus_addr; a_wd = ib.bus_wdata; a_rd = {ib.m1_rdata, ib.m0_rdata}; a_stall = ib.cpu_stall;
                end
                e_gnt   = (o == 0) ? 2'b01 : (o == 1) ? 2'b10 : 2'b00;
                e_ack   = {(o == 1) && ia.m1_req, (o == 0) && ia.m0_req};
                e_we    = (o == 0) ? (ia.m0_we && ia.m0_req) : (o == 1) ? (ia.m1_we && ia.m1_req) : 1'b0;
                e_addr  = (o == 0) ? ia.m0_addr : (o == 1) ? ia.m1_addr : 32'h0;
                e_wd    = (o == 0) ? ia.m0_wdata : (o == 1) ? ia.m1_wdata : 32'h0;
                e_rd    = {(o == 1) ? ia.bus_rdata : 32'h0, (o == 0) ? ia.bus_rdata : 32'h0};
                e_stall = ia.m0_req && !e_ack[0];
                all_ack0 &= e_ack[0];
                all_ack1 &= e_ack[1];
                n_checks++;
                if (a_gnt !== e_gnt) begin
                    n_fail++; $display("FAIL rnd_gnt i=%0d k=%0d: got %b expected %b", i, k, a_gnt, e_gnt);
                end
                n_checks++;
                if (a_ack !== e_ack) begin
                    n_fail++; $display("FAIL rnd_ack i=%0d k=%0d: got %b expected %b", i, k, a_ack, e_ack);
                end
                n_checks++;
                if (a_we !== e_we) begin
                    n_fail++; $display("FAIL rnd_we i=%0d k=%0d: got %b expected %b", i, k, a_we, e_we);
                end
                n_checks++;
                if (a_addr !== e_addr || a_wd !== e_wd) begin
                    n_fail++; $display("FAIL rnd_payload i=%0d k=%0d: got %h/%h expected %h/%h", i, k, a_addr, a_wd, e_addr, e_wd);
                end
                n_checks++;
                if (a_rd !== e_rd) begin
                    n_fail++; $display("FAIL rnd_rdata i=%0d k=%0d: got %h expected %h", i, k, a_rd, e_rd);
                end
                n_checks++;
                if (a_stall !== e_stall) begin
                    n_fail++; $display("FAIL rnd_stall i=%0d k=%0d: got %b expected %b", i, k, a_stall, e_stall);
                end
            end
            @(posedge clk);
            model_step(ia.m0_req, ia.m1_req);
            #1;
            // A pending request keeps its payload until both instances have acked it.
            if (ia.m0_req && !all_ack0) begin
                if ($urandom_range(0, 9) == 0) ia.m0_req = 1'b0;
            end else begin
                ia.m0_req = ($urandom_range(0, 3) != 0);
                ia.m0_we = 1'($urandom_range(0, 1)); ia.m0_addr = $urandom;
                ia.m0_wdata = $urandom; ia.m0_amp = 4'($urandom_range(0, 15));
            end
            if (ia.m1_req && !all_ack1) begin
                if ($urandom_range(0, 9) == 0) ia.m1_req = 1'b0;
            end else begin
                ia.m1_req = ($urandom_range(0, 3) != 0);
                ia.m1_we = 1'($urandom_range(0, 1)); ia.m1_addr = $urandom;
                ia.m1_wdata = $urandom; ia.m1_amp = 4'($urandom_range(0, 15));
            end
        end
        clear_inputs();
    endtask

    initial begin
        rstn = 1'b0;
        clear_inputs();
        model_reset();
        test_reset();
        test_single_read();
        test_round_robin();
        test_m1_write();
        test_release();
        test_reset_mid_write();
        test_burst1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within 1 ms");
        $fatal(1, "watchdog expired");
    end
endmodule
